bus_dev_port: RTL and testbench
===============================

// Module: bus_dev_port
// PURPOSE
//  Device-side endpoint of the shared bus generator/arbiter: the FIFO pair that the bus pops from and pushes into.
//  TX FIFO: device writes packets; bus reads them via pndng/pop/D_pop (show-ahead).
//  RX FIFO: bus writes packets via push/D_push; device drains them.
//  One instance per bus device slot; RTL replacement for the behavioural FIFO in the driver model.
// PARAMETERS
//  PCKG_SZ    16     packet width; dest ID in bits [PCKG_SZ-1 -: ID_W]
//  ID_W       8      destination-ID field width
//  DEPTH      8      entries per FIFO, power of 2, >=2
//  DEV_ID     0      this device's bus ID
//  BROADCAST  '1     ID_W-bit broadcast ID
// PORTS
//  clk          in   1             single clock, rising edge
//  reset        in   1             sync, active-low
//  pndng        out  1             TX FIFO non-empty
//  D_pop        out  PCKG_SZ       TX head packet, valid while pndng=1
//  pop          in   1             bus consumes TX head this cycle
//  push         in   1             bus delivers D_push this cycle
//  D_push       in   PCKG_SZ       packet from bus
//  tx_valid     in   1             device offers tx_data
//  tx_data      in   PCKG_SZ       packet to send
//  tx_ready     out  1             TX not full
//  rx_valid     out  1             RX non-empty
//  rx_data      out  PCKG_SZ       RX head packet
//  rx_ready     in   1             device consumes RX head
//  tx_level     out  $clog2(DEPTH+1)  TX occupancy
//  rx_drop_cnt  out  16            dropped-packet count, saturating at 16'hFFFF
//  pop_err      out  1             sticky: pop seen while TX empty
// BEHAVIOUR
//  - Reset (reset=0 at posedge): ptrs/counts=0, pndng=0, rx_valid=0, tx_ready=1,
//    rx_drop_cnt=0, pop_err=0; D_pop/rx_data don't-care. Reset mid-transfer discards all contents.
//  - Flags from registered counts only; no combinational input->flag paths.
//  - TX write: tx_valid&tx_ready at posedge; packet visible on D_pop/pndng the next cycle (1-cycle latency).
//  - Full: tx_ready=0 even if pop in same cycle (no write-through at full).
//  - Empty with simultaneous write and read: write accepted, pop ignored, pop_err set.
//  - pop while pndng=0: no state change except pop_err<=1 (held until reset).
//  - pop&pndng: rd_ptr advances; next entry on D_pop the following cycle.
//  - Ptrs wrap DEPTH-1 -> 0; level = count register, both directions same cycle leaves it unchanged.
//  - RX: push with D_push accepted -> rx_valid next cycle; rx_ready&rx_valid pops head.
//  - RX push while full (registered): packet dropped, rx_drop_cnt+1; simultaneous rx_ready does not rescue it.
//  - push with D_push==0 is still a packet (no null filtering).
// CONFIGURATION
//  BUS_DEV_ADDR_FILTER_EN defined: RX accepts only dest==DEV_ID or dest==BROADCAST;
//    others dropped and counted in rx_drop_cnt.
//  Undefined: every push accepted regardless of dest; rx_drop_cnt counts overflow only.
// STRUCTURE
//  - Package bus_dev_pkg:
//    - ID_W localparam default
//    - function pkt_dest(pkt) extracting the dest field
//    - typedef of {dest, payload} packet struct, parameterised via PCKG_SZ
//  - Sub-module bus_dev_fifo (sync show-ahead FIFO with count, full, empty):
//    - instanced twice (TX, RX)
//    - top adds addr filter, drop counter, pop_err
// TESTING
//  1 Reset: hold reset=0 3 cycles mid-traffic -> pndng=0, rx_valid=0, tx_ready=1, rx_drop_cnt=0, pop_err=0.
//  2 TX order: write 16'h0A01,16'h0A02,16'h0A03; pop each cycle -> D_pop shows 0A01,0A02,0A03 in order;
//    pndng=0 after 3rd pop; tx_level 3->0.
//  3 TX full: DEPTH=8, write 9 -> tx_ready=0 after 8th, 9th not stored;
//    pop+tx_valid same cycle at full -> level 7 next cycle.
//  4 pop with pndng=0 -> pop_err=1 persists until reset; FIFO contents untouched.
//  5 RX overflow: 9 pushes, rx_ready=0 -> rx_valid=1, 8 packets drained in order, rx_drop_cnt=1.
//  6 With BUS_DEV_ADDR_FILTER_EN, DEV_ID=3: push 16'h0355, 16'hFF66, 16'h0277 -> RX holds 0355, FF66;
//    rx_drop_cnt=1. Without macro -> all 3 stored.

Source files
------------

// File: rtl/bus_dev_pkg.sv
// rtl/bus_dev_pkg.sv - shared types and defaults for the bus device port
//
// Purpose: default packet geometry, the {dest, payload} packet view and a
//          helper that extracts the destination ID from a packet.
// Ports:   none (package).
package bus_dev_pkg;

   localparam int unsigned BUS_ID_W    = 8;
   localparam int unsigned BUS_PCKG_SZ = 16;

   typedef struct packed {
      logic [BUS_ID_W-1:0]             dest;
      logic [BUS_PCKG_SZ-BUS_ID_W-1:0] payload;
   } bus_pkt_t;

   function automatic logic [BUS_ID_W-1:0] pkt_dest(input bus_pkt_t pkt);
      return pkt.dest;
   endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// rtl/bus_dev_fifo.sv - synchronous show-ahead FIFO with occupancy count
//
// Purpose: single-clock FIFO; the head entry is always presented on rd_data_o.
//          Writes are ignored when full, reads are ignored when empty, so the
//          caller may drive the enables unconditionally.
// Ports:
//   clk_i      clock, rising edge
//   resetn_i   synchronous active-low reset (pointers and count only)
//   wr_en_i    write request, wr_data_i captured if not full
//   rd_en_i    read request, head retired if not empty
//   rd_data_o  head entry, meaningful while empty_o=0
//   count_o    registered occupancy 0..DEPTH
//   empty_o    registered empty flag
module bus_dev_fifo
#(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8
)(
   input  logic                       clk_i,
   input  logic                       resetn_i,
   input  logic                       wr_en_i,
   input  logic [W-1:0]               wr_data_i,
   input  logic                       rd_en_i,
   output logic [W-1:0]               rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ok, rd_ok;

   always_comb begin
      wr_ok    = wr_en_i && (count_q != FULL_CNT);
      rd_ok    = rd_en_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign empty_o   = (count_q == '0);

endmodule

// File: rtl/bus_dev_port.sv
// rtl/bus_dev_port.sv - device-side TX/RX FIFO endpoint of the shared bus
//
// Purpose: TX FIFO filled by the device and drained by the bus (pndng/pop/D_pop,
//          show-ahead); RX FIFO filled by the bus (push/D_push) and drained by
//          the device. Counts dropped RX packets and flags pops on an empty TX.
// Config:  BUS_DEV_ADDR_FILTER_EN - when defined, RX accepts only packets whose
//          dest field equals DEV_ID or BROADCAST; others are dropped and counted.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   pndng, D_pop, pop     bus side of TX FIFO
//   push, D_push          bus side of RX FIFO
//   tx_valid/data/ready   device side of TX FIFO
//   rx_valid/data/ready   device side of RX FIFO
//   tx_level              TX occupancy
//   rx_drop_cnt           saturating dropped-packet counter
//   pop_err               sticky pop-while-empty flag
module bus_dev_port
   import bus_dev_pkg::*;
#(
   parameter int unsigned     PCKG_SZ   = BUS_PCKG_SZ,
   parameter int unsigned     ID_W      = BUS_ID_W,
   parameter int unsigned     DEPTH     = 8,
   parameter logic [ID_W-1:0] DEV_ID    = '0,
   parameter logic [ID_W-1:0] BROADCAST = '1
)(
   input  logic                       clk,
   input  logic                       reset,
   output logic                       pndng,
   output logic [PCKG_SZ-1:0]         D_pop,
   input  logic                       pop,
   input  logic                       push,
   input  logic [PCKG_SZ-1:0]         D_push,
   input  logic                       tx_valid,
   input  logic [PCKG_SZ-1:0]         tx_data,
   output logic                       tx_ready,
   output logic                       rx_valid,
   output logic [PCKG_SZ-1:0]         rx_data,
   input  logic                       rx_ready,
   output logic [$clog2(DEPTH+1)-1:0] tx_level,
   output logic [15:0]                rx_drop_cnt,
   output logic                       pop_err
);

   localparam int unsigned LVL_W = $clog2(DEPTH+1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

`ifdef BUS_DEV_ADDR_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   logic [ID_W-1:0]  push_dest;
   logic             addr_ok;
   logic             rx_full;
   logic             rx_accept;
   logic             rx_drop;
   logic             tx_empty, rx_empty;
   logic [LVL_W-1:0] tx_count, rx_count;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             pop_err_q, pop_err_d;

   bus_dev_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
      .clk_i     (clk),
      .resetn_i  (reset),
      .wr_en_i   (tx_valid),
      .wr_data_i (tx_data),
      .rd_en_i   (pop),
      .rd_data_o (D_pop),
      .count_o   (tx_count),
      .empty_o   (tx_empty)
   );

   bus_dev_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
      .clk_i     (clk),
      .resetn_i  (reset),
      .wr_en_i   (rx_accept),
      .wr_data_i (D_push),
      .rd_en_i   (rx_ready),
      .rd_data_o (rx_data),
      .count_o   (rx_count),
      .empty_o   (rx_empty)
   );

   always_comb begin
      push_dest = D_push[PCKG_SZ-1 -: ID_W];
      addr_ok   = !FILTER_EN || (push_dest == DEV_ID) || (push_dest == BROADCAST);
      // Full is judged on the registered count: a same-cycle rx_ready does
      // not make room for the incoming packet.
      rx_full   = (rx_count == FULL_LVL);
      rx_accept = push && addr_ok && !rx_full;
      rx_drop   = push && !rx_accept;

      drop_cnt_d = drop_cnt_q;
      if (rx_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

      pop_err_d = pop_err_q || (pop && tx_empty);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         drop_cnt_q <= '0;
         pop_err_q  <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         pop_err_q  <= pop_err_d;
      end
   end

   assign pndng       = !tx_empty;
   assign tx_ready    = (tx_count != FULL_LVL);
   assign tx_level    = tx_count;
   assign rx_valid    = !rx_empty;
   assign rx_drop_cnt = drop_cnt_q;
   assign pop_err     = pop_err_q;

endmodule

// File: tb/tb_bus_dev_port.sv
// tb/tb_bus_dev_port.sv - self-checking bench for bus_dev_port
module tb_bus_dev_port;
   import bus_dev_pkg::*;

   localparam int DEPTH = 8;
   localparam logic [7:0] DEV_ID_TB = 8'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pndng;
   logic [15:0] D_pop;
   logic        pop = 1'b0;
   logic        push = 1'b0;
   logic [15:0] D_push = '0;
   logic        tx_valid = 1'b0;
   logic [15:0] tx_data = '0;
   logic        tx_ready;
   logic        rx_valid;
   logic [15:0] rx_data;
   logic        rx_ready = 1'b0;
   logic [3:0]  tx_level;
   logic [15:0] rx_drop_cnt;
   logic        pop_err;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] m_tx[$];
   logic [15:0] m_rx[$];
   int          m_drop = 0;
   bit          m_perr = 1'b0;

   bus_dev_port #(.PCKG_SZ(16), .ID_W(8), .DEPTH(DEPTH), .DEV_ID(DEV_ID_TB), .BROADCAST(8'hFF)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_level(tx_level), .rx_drop_cnt(rx_drop_cnt), .pop_err(pop_err)
   );

   always #5 clk = ~clk;

   function automatic bit addr_ok(input logic [15:0] pkt);
`ifdef BUS_DEV_ADDR_FILTER_EN
      bus_pkt_t p;
      p = pkt;
      return (pkt_dest(p) == DEV_ID_TB) || (pkt_dest(p) == 8'hFF);
`else
      return 1'b1;
`endif
   endfunction

   // Apply one cycle of inputs at the falling edge, advance the reference
   // model by the same posedge, and return at the next falling edge.
   task automatic step(input logic tv, input logic [15:0] td, input logic p,
                       input logic pu, input logic [15:0] dp, input logic rr);
      bit tx_acc, rx_acc;
      tx_valid = tv; tx_data = td; pop = p; push = pu; D_push = dp; rx_ready = rr;
      tx_acc = tv && (m_tx.size() < DEPTH);
      if (p) begin
         if (m_tx.size() > 0) void'(m_tx.pop_front());
         else m_perr = 1'b1;
      end
      if (tx_acc) m_tx.push_back(td);
      rx_acc = pu && addr_ok(dp) && (m_rx.size() < DEPTH);
      if (pu && !rx_acc && m_drop < 65535) m_drop++;
      if (rr && m_rx.size() > 0) void'(m_rx.pop_front());
      if (rx_acc) m_rx.push_back(dp);
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0; pop = 1'b0; push = 1'b0; rx_ready = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   // Reset held for three edges while traffic is being offered.
   task automatic do_reset();
      reset = 1'b0;
      tx_valid = 1'b1; tx_data = 16'hDEAD; pop = 1'b1;
      push = 1'b1; D_push = 16'h0311; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tx_valid = 1'b0; pop = 1'b0; push = 1'b0; rx_ready = 1'b0;
      m_tx.delete(); m_rx.delete(); m_drop = 0; m_perr = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h1111, 1'b0, 1'b1, 16'h0322, 1'b0);
      step(1'b1, 16'h2222, 1'b0, 1'b1, 16'hFF33, 1'b0);
      tests_run++;
      if (pop_err !== 1'b1 || pndng !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_pre: pop_err=%b pndng=%b, required 1 1", pop_err, pndng);
      end
      do_reset();
      tests_run++;
      if (pndng !== 1'b0) begin tests_failed++; $display("FAIL reset_pndng: got %b required 0", pndng); end
      tests_run++;
      if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
      tests_run++;
      if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
      tests_run++;
      if (rx_drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_drop_cnt: got %0d required 0", rx_drop_cnt); end
      tests_run++;
      if (pop_err !== 1'b0) begin tests_failed++; $display("FAIL reset_pop_err: got %b required 0", pop_err); end
      tests_run++;
      if (tx_level !== 4'd0) begin tests_failed++; $display("FAIL reset_tx_level: got %0d required 0", tx_level); end
   endtask

   task automatic test_tx_order();
      logic [15:0] v [3];
      v[0] = 16'h0A01; v[1] = 16'h0A02; v[2] = 16'h0A03;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, v[i], 1'b0, 1'b0, 16'h0, 1'b0);
         tests_run++;
         if (tx_level !== 4'(i + 1)) begin
            tests_failed++;
            $display("FAIL tx_order_level_up: got %0d required %0d", tx_level, i + 1);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (pndng !== 1'b1 || D_pop !== v[i]) begin
            tests_failed++;
            $display("FAIL tx_order_head%0d: pndng=%b D_pop=%h, required 1 %h", i, pndng, D_pop, v[i]);
         end
         step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
         tests_run++;
         if (tx_level !== 4'(2 - i)) begin
            tests_failed++;
            $display("FAIL tx_order_level_down: got %0d required %0d", tx_level, 2 - i);
         end
      end
      tests_run++;
      if (pndng !== 1'b0) begin tests_failed++; $display("FAIL tx_order_empty: pndng=%b required 0", pndng); end
   endtask

   task automatic test_tx_full();
      logic [15:0] v [9];
      for (int i = 0; i < 9; i++) v[i] = 16'($urandom);
      for (int i = 0; i < 9; i++) begin
         step(1'b1, v[i], 1'b0, 1'b0, 16'h0, 1'b0);
         if (i >= 7) begin
            tests_run++;
            if (tx_ready !== 1'b0 || tx_level !== 4'd8) begin
               tests_failed++;
               $display("FAIL tx_full_after%0d: tx_ready=%b level=%0d, required 0 8", i + 1, tx_ready, tx_level);
            end
         end
      end
      step(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0);
      tests_run++;
      if (tx_level !== 4'd7 || tx_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL tx_full_pop_write: level=%0d tx_ready=%b, required 7 1", tx_level, tx_ready);
      end
      for (int i = 1; i < 8; i++) begin
         tests_run++;
         if (D_pop !== v[i]) begin
            tests_failed++;
            $display("FAIL tx_full_drain%0d: D_pop=%h required %h", i, D_pop, v[i]);
         end
         step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      end
      tests_run++;
      if (pndng !== 1'b0) begin tests_failed++; $display("FAIL tx_full_end_empty: pndng=%b required 0", pndng); end
   endtask

   task automatic test_pop_err();
      step(1'b1, 16'h4444, 1'b1, 1'b0, 16'h0, 1'b0);
      tests_run++;
      if (pndng !== 1'b1 || tx_level !== 4'd1 || D_pop !== 16'h4444 || pop_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL pop_err_write_on_empty: pndng=%b level=%0d D_pop=%h pop_err=%b, required 1 1 4444 1",
                  pndng, tx_level, D_pop, pop_err);
      end
      repeat (3) idle();
      tests_run++;
      if (pop_err !== 1'b1 || tx_level !== 4'd1 || D_pop !== 16'h4444) begin
         tests_failed++;
         $display("FAIL pop_err_sticky: pop_err=%b level=%0d D_pop=%h, required 1 1 4444", pop_err, tx_level, D_pop);
      end
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      tests_run++;
      if (tx_level !== 4'd0 || pop_err !== 1'b1 || tx_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL pop_err_empty_pop: level=%0d pop_err=%b tx_ready=%b, required 0 1 1", tx_level, pop_err, tx_ready);
      end
      do_reset();
      tests_run++;
      if (pop_err !== 1'b0) begin tests_failed++; $display("FAIL pop_err_cleared: got %b required 0", pop_err); end
   endtask

   task automatic test_rx_overflow();
      logic [15:0] v [9];
      for (int i = 0; i < 9; i++) v[i] = {8'h03, 8'($urandom)};
      for (int i = 0; i < 9; i++) step(1'b0, 16'h0, 1'b0, 1'b1, v[i], 1'b0);
      tests_run++;
      if (rx_valid !== 1'b1 || rx_drop_cnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL rx_overflow_state: rx_valid=%b drop=%0d, required 1 1", rx_valid, rx_drop_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (rx_valid !== 1'b1 || rx_data !== v[i]) begin
            tests_failed++;
            $display("FAIL rx_overflow_drain%0d: rx_valid=%b rx_data=%h, required 1 %h", i, rx_valid, rx_data, v[i]);
         end
         step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
      end
      tests_run++;
      if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rx_overflow_empty: rx_valid=%b required 0", rx_valid); end
      for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b0, 1'b1, v[i], 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'h03AA, 1'b1);
      tests_run++;
      if (rx_drop_cnt !== 16'd2) begin
         tests_failed++;
         $display("FAIL rx_overflow_no_rescue: drop=%0d required 2", rx_drop_cnt);
      end
      do_reset();
   endtask

   task automatic test_addr_filter();
      logic [15:0] p [4];
      logic [15:0] exp_q[$];
      int          exp_drop;
      p[0] = 16'h0355; p[1] = 16'hFF66; p[2] = 16'h0277; p[3] = 16'h0000;
`ifdef BUS_DEV_ADDR_FILTER_EN
      exp_q = '{16'h0355, 16'hFF66};
      exp_drop = 2;
`else
      exp_q = '{16'h0355, 16'hFF66, 16'h0277, 16'h0000};
      exp_drop = 0;
`endif
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1, p[i], 1'b0);
      tests_run++;
      if (rx_drop_cnt !== 16'(exp_drop)) begin
         tests_failed++;
         $display("FAIL addr_filter_drop: got %0d required %0d", rx_drop_cnt, exp_drop);
      end
      foreach (exp_q[i]) begin
         tests_run++;
         if (rx_valid !== 1'b1 || rx_data !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL addr_filter_entry%0d: rx_valid=%b rx_data=%h, required 1 %h", i, rx_valid, rx_data, exp_q[i]);
         end
         step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
      end
      tests_run++;
      if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL addr_filter_empty: rx_valid=%b required 0", rx_valid); end
   endtask

   task automatic test_random();
      int r;
      logic [15:0] dp;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         r = $urandom_range(0, 3);
         case (r)
            0:       dp = {8'h03, 8'($urandom)};
            1:       dp = {8'hFF, 8'($urandom)};
            2:       dp = 16'($urandom);
            default: dp = 16'h0000;
         endcase
         step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 5,
              $urandom_range(0, 9) < 6, dp, $urandom_range(0, 9) < 4);
         tests_run++;
         if (pndng !== (m_tx.size() != 0) || tx_level !== 4'(m_tx.size()) || tx_ready !== (m_tx.size() < DEPTH)) begin
            tests_failed++;
            $display("FAIL rand_tx_flags c=%0d: pndng=%b level=%0d ready=%b, required size %0d", c, pndng, tx_level, tx_ready, m_tx.size());
         end
         if (m_tx.size() > 0) begin
            tests_run++;
            if (D_pop !== m_tx[0]) begin
               tests_failed++;
               $display("FAIL rand_tx_head c=%0d: D_pop=%h required %h", c, D_pop, m_tx[0]);
            end
         end
         tests_run++;
         if (rx_valid !== (m_rx.size() != 0) || rx_drop_cnt !== 16'(m_drop) || pop_err !== m_perr) begin
            tests_failed++;
            $display("FAIL rand_rx_status c=%0d: rx_valid=%b drop=%0d pop_err=%b, required %b %0d %b",
                     c, rx_valid, rx_drop_cnt, pop_err, m_rx.size() != 0, m_drop, m_perr);
         end
         if (m_rx.size() > 0) begin
            tests_run++;
            if (rx_data !== m_rx[0]) begin
               tests_failed++;
               $display("FAIL rand_rx_head c=%0d: rx_data=%h required %h", c, rx_data, m_rx[0]);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_tx_order();
      test_tx_full();
      test_pop_err();
      test_rx_overflow();
      test_addr_filter();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
